// File: rtl/cska_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cska_pkg
//  Purpose : Shared constants and elaboration helpers for the pipelined
//            carry-skip adder/subtractor.
//  Rev     : 1.0  initial parametrised release
// ============================================================================
package cska_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Number of skip blocks covering a given width
   function automatic int nblk(input int width, input int blk);
      return width / blk;
   endfunction

   // Legal parameter set: slices split evenly into whole blocks
   function automatic bit cfg_ok(input int width, input int blk, input int stages);
      if (blk < 1 || stages < 1) return 1'b0;
      return ((width % (blk * stages)) == 0) && (stages <= width / blk);
   endfunction

   // Width of the register word that leaves stage k. Intermediate stages
   // carry the finished low sum bits, the untouched upper A and B bits and
   // the slice carry; the last stage carries the full sum, cout and ovf.
   function automatic int seg_w(input int k, input int width, input int stages);
      if (k == stages - 1) return width + 2;
      return 2 * width - (k + 1) * (width / stages) + 1;
   endfunction

   // Bit offset of stage k's word inside the flat pipeline register
   function automatic int seg_off(input int k, input int width, input int stages);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) off += seg_w(j, width, stages);
      return off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cska_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module  : cska_pipe_if
//  Purpose : Operand / result handshake bundle for cska_pipe.
//  Rev     : 1.0  initial parametrised release
// ============================================================================
interface cska_pipe_if #(
   parameter int WIDTH = 32
) ();
   import cska_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // Producer/consumer side
   modport master (
      output in_valid, inA, inB, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   // Adder side
   modport slave (
      input  in_valid, inA, inB, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/cska_blk.sv
`default_nettype none
// ============================================================================
//  Module  : cska_blk
//  Purpose : BLK-bit ripple-carry block with carry-skip multiplexer.
//  Rev     : 1.0  initial parametrised release
// ============================================================================
module cska_blk
   import cska_pkg::*;
#(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           ci,
   output logic [BLK-1:0] s,
   output logic           co
);

   logic [BLK-1:0] w_p;
   logic [BLK:0]   w_c;

   assign w_p = a ^ b;

   // Ripple the carry bit by bit through the block
   always_comb begin
      w_c    = '0;
      w_c[0] = ci;
      for (int i = 0; i < BLK; i++) begin
         w_c[i+1] = (a[i] & b[i]) | (w_p[i] & w_c[i]);
      end
   end

   assign s  = w_p ^ w_c[BLK-1:0];
   // When every bit propagates the carry-in bypasses the ripple chain
   assign co = (&w_p) ? ci : w_c[BLK];

endmodule
`default_nettype wire

// File: rtl/cska_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : cska_pipe
//  Purpose : Pipelined carry-skip adder/subtractor with valid/ready
//            handshake. Stage k resolves bit slice k; the whole pipe
//            freezes while the result is stalled.
//  Rev     : 1.0  initial parametrised release
// ============================================================================
module cska_pipe
   import cska_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLK    = 4,
   parameter int STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   cska_pipe_if.slave bus
);

   localparam int SL = WIDTH / STAGES;               // bits resolved per stage
   localparam int NB = nblk(SL, BLK);                // skip blocks per stage
   localparam int PW = seg_off(STAGES, WIDTH, STAGES);
   localparam int FO = seg_off(STAGES - 1, WIDTH, STAGES);

   if (!cfg_ok(WIDTH, BLK, STAGES)) begin : g_cfg_check
      $error("cska_pipe: WIDTH must be a multiple of BLK*STAGES and STAGES <= WIDTH/BLK");
   end

   logic [STAGES-1:0] r_valid;
   logic [PW-1:0]     r_pipe;     // all stage words, stage 0 at the LSB end
   logic [PW-1:0]     w_pipe_d;
   logic              w_stall;
   logic              w_fire;

   assign w_stall       = r_valid[STAGES-1] & ~bus.out_ready;
   assign w_fire        = bus.in_valid & ~w_stall;
   assign bus.in_ready  = ~w_stall;
   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.sum       = r_pipe[FO +: WIDTH];
   assign bus.cout      = r_pipe[FO + WIDTH];
   assign bus.ovf       = r_pipe[FO + WIDTH + 1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * SL;                   // low bit of this slice
      localparam int UIN = WIDTH - LO;               // operand bits still pending
      localparam int OFF = seg_off(k, WIDTH, STAGES);

      logic [UIN-1:0] w_a;
      logic [UIN-1:0] w_b;
      logic           w_ci;
      logic [SL-1:0]  w_s;
      logic [NB:0]    w_c;

      if (k == 0) begin : g_src_in
         // Subtraction is A + ~B + 1; cin only matters when adding
         assign w_a  = bus.inA;
         assign w_b  = (bus.sub == MODE_SUB) ? ~bus.inB : bus.inB;
         assign w_ci = (bus.sub == MODE_ADD) ? bus.cin : 1'b1;
      end else begin : g_src_reg
         localparam int PO = seg_off(k - 1, WIDTH, STAGES);
         assign w_a  = r_pipe[PO + LO +: UIN];
         assign w_b  = r_pipe[PO + LO + UIN +: UIN];
         assign w_ci = r_pipe[PO + LO + 2 * UIN];
         assign w_pipe_d[OFF +: LO] = r_pipe[PO +: LO];
      end

      assign w_c[0] = w_ci;
      for (genvar j = 0; j < NB; j++) begin : g_blk
         cska_blk #(.BLK(BLK)) u_blk (
            .a  (w_a[j*BLK +: BLK]),
            .b  (w_b[j*BLK +: BLK]),
            .ci (w_c[j]),
            .s  (w_s[j*BLK +: BLK]),
            .co (w_c[j+1])
         );
      end

      assign w_pipe_d[OFF + LO +: SL] = w_s;

      if (k < STAGES - 1) begin : g_mid
         localparam int U = UIN - SL;
         assign w_pipe_d[OFF + LO + SL +: U]     = w_a[UIN-1:SL];
         assign w_pipe_d[OFF + LO + SL + U +: U] = w_b[UIN-1:SL];
         assign w_pipe_d[OFF + LO + SL + 2 * U]  = w_c[NB];
      end else begin : g_last
         logic w_cmsb;
         // Carry into the MSB recovered from the MSB sum bit
         assign w_cmsb = w_s[SL-1] ^ w_a[SL-1] ^ w_b[SL-1];
         assign w_pipe_d[OFF + WIDTH]     = w_c[NB];
         assign w_pipe_d[OFF + WIDTH + 1] = w_cmsb ^ w_c[NB];
      end
   end

   // Advance every stage together unless the result is held by the consumer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_pipe  <= '0;
      end else if (!w_stall) begin
         r_valid[0] <= w_fire;
         for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
         end
         r_pipe <= w_pipe_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cska_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_cska_pipe
//  Purpose : Self-checking bench for cska_pipe at (32,4,2), (16,2,4) and
//            (64,8,1) against a plain-arithmetic reference model.
//  Rev     : 1.0  initial parametrised release
// ============================================================================
module tb_cska_pipe;
   import cska_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cska_pipe_if #(.WIDTH(32)) b32 ();
   cska_pipe_if #(.WIDTH(16)) b16 ();
   cska_pipe_if #(.WIDTH(64)) b64 ();

   cska_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   cska_pipe #(.WIDTH(16), .BLK(2), .STAGES(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   cska_pipe #(.WIDTH(64), .BLK(8), .STAGES(1)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_out32  = 0;
   logic [65:0] q32[$];
   logic [65:0] q16[$];
   logic [65:0] q64[$];

   task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from integer arithmetic on w-bit values
   function automatic logic [65:0] ref_addsub(input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input logic sub, input int w);
      logic [64:0] mask, ae, be, full;
      logic [63:0] s;
      logic        co, ov;
      mask = (65'd1 << w) - 65'd1;
      ae   = {1'b0, a} & mask;
      be   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
      full = ae + be + {64'd0, (sub ? 1'b1 : cin)};
      co   = full[w];
      s    = full[63:0] & mask[63:0];
      ov   = (ae[w-1] == be[w-1]) && (s[w-1] != ae[w-1]);
      return {ov, co, s};
   endfunction

   // Operand generator biased toward corner values
   function automatic logic [63:0] rand_op(input int w);
      logic [63:0] mask;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return mask;
         2:       return 64'd1 << (w - 1);
         3:       return mask >> 1;
         4:       return 64'd1;
         default: return {$urandom, $urandom} & mask;
      endcase
   endfunction

   // 32-bit scoreboard plus stall-stability and in_ready checks
   logic        stall_prev = 1'b0;
   logic [65:0] out_prev   = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         q32.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check_eq("w32_stall_hold", {b32.out_valid, b32.ovf, b32.cout, b32.sum}, out_prev);
         check_eq("w32_in_ready", b32.in_ready, !(b32.out_valid && !b32.out_ready));
         if (b32.out_valid && b32.out_ready) begin
            n_out32++;
            check_eq("w32_result_expected", q32.size() != 0, 1'b1);
            if (q32.size() != 0)
               check_eq("w32_result", {b32.ovf, b32.cout, 32'd0, b32.sum}, q32.pop_front());
         end
         if (b32.in_valid && b32.in_ready)
            q32.push_back(ref_addsub(64'(b32.inA), 64'(b32.inB), b32.cin, b32.sub, 32));
         stall_prev = b32.out_valid && !b32.out_ready;
         out_prev   = {b32.out_valid, b32.ovf, b32.cout, b32.sum};
      end
   end

   // 16-bit scoreboard
   always @(negedge clk) begin
      if (!rst_n) q16.delete();
      else begin
         if (b16.out_valid && b16.out_ready) begin
            check_eq("w16_result_expected", q16.size() != 0, 1'b1);
            if (q16.size() != 0)
               check_eq("w16_result", {b16.ovf, b16.cout, 48'd0, b16.sum}, q16.pop_front());
         end
         if (b16.in_valid && b16.in_ready)
            q16.push_back(ref_addsub(64'(b16.inA), 64'(b16.inB), b16.cin, b16.sub, 16));
      end
   end

   // 64-bit scoreboard
   always @(negedge clk) begin
      if (!rst_n) q64.delete();
      else begin
         if (b64.out_valid && b64.out_ready) begin
            check_eq("w64_result_expected", q64.size() != 0, 1'b1);
            if (q64.size() != 0)
               check_eq("w64_result", {b64.ovf, b64.cout, b64.sum}, q64.pop_front());
         end
         if (b64.in_valid && b64.in_ready)
            q64.push_back(ref_addsub(b64.inA, b64.inB, b64.cin, b64.sub, 64));
      end
   end

   // One directed 32-bit operation: latency and result against constants
   task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s, input logic [33:0] exp);
      int lat;
      b32.inA = a; b32.inB = b; b32.cin = c; b32.sub = s;
      b32.in_valid = 1'b1; b32.out_ready = 1'b1;
      check_eq({tag, "_in_ready"}, b32.in_ready, 1'b1);
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      lat = 1;
      while (!b32.out_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_latency"}, lat, 2);
      check_eq({tag, "_result"}, {b32.ovf, b32.cout, b32.sum}, exp);
      @(posedge clk); #1;
   endtask

   task automatic idle_all();
      b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.cin = 1'b0; b32.sub = MODE_ADD;
      b32.inA = '0; b32.inB = '0;
      b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.cin = 1'b0; b16.sub = MODE_ADD;
      b16.inA = '0; b16.inB = '0;
      b64.in_valid = 1'b0; b64.out_ready = 1'b1; b64.cin = 1'b0; b64.sub = MODE_ADD;
      b64.inA = '0; b64.inB = '0;
   endtask

   initial begin
      int base, sent, stall_seen;
      idle_all();

      // Reset state
      #12;
      check_eq("rst_out_valid", b32.out_valid, 1'b0);
      check_eq("rst_result", {b32.ovf, b32.cout, b32.sum}, 34'd0);
      check_eq("rst_in_ready", b32.in_ready, 1'b1);
      check_eq("rst_w16_valid", b16.out_valid, 1'b0);
      check_eq("rst_w64_valid", b64.out_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases: expected {ovf, cout, sum}
      op32("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, {2'b01, 32'h0000_0000});
      op32("skip_ci",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, MODE_ADD, {2'b01, 32'h0000_0000});
      op32("skip_prop", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, MODE_ADD, {2'b00, 32'hFFFF_FFFF});
      op32("sub_neg",   32'd5,         32'd7,         1'b1, MODE_SUB, {2'b00, 32'hFFFF_FFFE});
      op32("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, {2'b10, 32'h8000_0000});
      op32("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, {2'b11, 32'h7FFF_FFFF});
      op32("sub_noci",  32'd10,        32'd3,         1'b0, MODE_SUB, {2'b01, 32'h0000_0007});

      // Backpressure: six ops, consumer stalls in cycles 3..7
      sent = 0; stall_seen = 0; base = n_out32;
      for (int cyc = 0; cyc < 40 && (sent < 6 || b32.out_valid); cyc++) begin
         b32.out_ready = !(cyc >= 3 && cyc <= 7);
         b32.in_valid  = (sent < 6);
         b32.inA = $urandom; b32.inB = $urandom; b32.cin = $urandom; b32.sub = $urandom;
         @(negedge clk);
         if (b32.out_valid && !b32.out_ready) stall_seen = 1;
         if (b32.in_valid && b32.in_ready) sent++;
         @(posedge clk); #1;
      end
      b32.in_valid = 1'b0; b32.out_ready = 1'b1;
      check_eq("bp_sent", sent, 6);
      check_eq("bp_stalled", stall_seen, 1);
      check_eq("bp_out_count", n_out32 - base, 6);
      check_eq("bp_drained", q32.size(), 0);

      // Throughput: eight back-to-back ops, one result per cycle
      base = n_out32;
      for (int i = 0; i < 8; i++) begin
         b32.inA = $urandom; b32.inB = $urandom; b32.cin = $urandom; b32.sub = $urandom;
         b32.in_valid = 1'b1;
         check_eq("tp_in_ready", b32.in_ready, 1'b1);
         @(posedge clk); #1;
      end
      b32.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_eq("tp_out_count", n_out32 - base, 8);
      @(posedge clk); #1;

      // Reset with two operations in flight
      b32.inA = 32'h1234_5678; b32.inB = 32'h1111_1111; b32.cin = 1'b0; b32.sub = MODE_ADD;
      b32.in_valid = 1'b1;
      @(posedge clk); #1;
      b32.inA = 32'h0F00_00F0;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      check_eq("rmid_pre_valid", b32.out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rmid_out_valid", b32.out_valid, 1'b0);
      check_eq("rmid_result", {b32.ovf, b32.cout, b32.sum}, 34'd0);
      base = n_out32;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_eq("rmid_no_stale", n_out32 - base, 0);
      check_eq("rmid_idle_valid", b32.out_valid, 1'b0);

      // Randomised sweep on all three parameter sets
      for (int cyc = 0; cyc < 600; cyc++) begin
         b32.in_valid  = ($urandom_range(0, 9) < 7);
         b32.out_ready = ($urandom_range(0, 9) < 7);
         b32.inA = 32'(rand_op(32));
         b32.inB = ($urandom_range(0, 7) == 0) ? ~b32.inA : 32'(rand_op(32));
         b32.cin = $urandom; b32.sub = $urandom;
         b16.in_valid  = ($urandom_range(0, 9) < 7);
         b16.out_ready = ($urandom_range(0, 9) < 7);
         b16.inA = 16'(rand_op(16));
         b16.inB = ($urandom_range(0, 7) == 0) ? ~b16.inA : 16'(rand_op(16));
         b16.cin = $urandom; b16.sub = $urandom;
         b64.in_valid  = ($urandom_range(0, 9) < 7);
         b64.out_ready = ($urandom_range(0, 9) < 7);
         b64.inA = rand_op(64);
         b64.inB = ($urandom_range(0, 7) == 0) ? ~b64.inA : rand_op(64);
         b64.cin = $urandom; b64.sub = $urandom;
         @(posedge clk); #1;
      end

      // Drain and confirm nothing was lost
      idle_all();
      repeat (10) @(posedge clk);
      #1;
      check_eq("drain_w32", q32.size(), 0);
      check_eq("drain_w16", q16.size(), 0);
      check_eq("drain_w64", q64.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
